// File: rtl/cud_ctrl_pkg.sv
// Shared types and default widths for the up/down counter sequence controller.
package cud_ctrl_pkg;

  localparam int CUD_WIDTH = 4;
  localparam int CUD_LEN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UP,
    ST_DOWN,
    ST_DONE
  } cud_state_e;

endpackage

// File: rtl/cud_len_cnt.sv
// Phase-length down-counter: loaded on phase entry, decremented each phase cycle.
module cud_len_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/counter_ud_ctrl.sv
// Sequencer driving an external up/down counter through load, count-up and
// count-down phases, tallying counter wraps along the way.
module counter_ud_ctrl
  import cud_ctrl_pkg::*;
#(
  parameter int WIDTH = CUD_WIDTH,
  parameter int LEN_W = CUD_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic [LEN_W-1:0] cfg_up_len,
  input  logic [LEN_W-1:0] cfg_dn_len,
  input  logic [WIDTH-1:0] count_i,
  input  logic             rollover_i,
  output logic             load_en,
  output logic [WIDTH-1:0] load,
  output logic             ud,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] roll_cnt
);

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

  cud_state_e       state_q, state_d;
  logic [WIDTH-1:0] load_q;
  logic [LEN_W-1:0] up_len_q, dn_len_q;
  logic [LEN_W-1:0] roll_q, roll_d;
  logic             accept;
  logic             up_nz, dn_nz;
  logic             ph_zero, ph_load, ph_dec;
  logic [LEN_W-1:0] ph_len;

  assign accept = (state_q == ST_IDLE) && start && !abort;
  assign up_nz  = (up_len_q != '0);
  assign dn_nz  = (dn_len_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A phase ends on the cycle its down-counter reads zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = up_nz ? ST_UP : (dn_nz ? ST_DOWN : ST_DONE);
      ST_UP:   if (ph_zero) state_d = dn_nz ? ST_DOWN : ST_DONE;
      ST_DOWN: if (ph_zero) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    load_en = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
    ud      = (state_q != ST_DOWN);
    load    = (state_q == ST_LOAD) ? load_q : count_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= '0;
      up_len_q <= '0;
      dn_len_q <= '0;
    end else if (accept) begin
      load_q   <= cfg_load;
      up_len_q <= cfg_up_len;
      dn_len_q <= cfg_dn_len;
    end
  end

  // Loading length-1 lets the full 2^LEN_W-1 range fit without an extra bit.
  assign ph_load = ((state_d == ST_UP) && (state_q != ST_UP)) ||
                   ((state_d == ST_DOWN) && (state_q != ST_DOWN));
  assign ph_len  = ((state_d == ST_UP) ? up_len_q : dn_len_q) - LEN_W'(1);
  assign ph_dec  = (state_q == ST_UP) || (state_q == ST_DOWN);

  cud_len_cnt #(
    .LEN_W(LEN_W)
  ) u_len_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ph_load),
    .load_val_i(ph_len),
    .dec_i     (ph_dec),
    .zero_o    (ph_zero)
  );

  always_comb begin
    roll_d = roll_q;
    if (accept) begin
      roll_d = '0;
    end else if (ph_dec && rollover_i) begin
      roll_d = sat_inc(roll_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roll_q <= '0;
    end else begin
      roll_q <= roll_d;
    end
  end

  assign roll_cnt = roll_q;

endmodule

// File: tb/tb_counter_ud_ctrl.sv
// Directed bench for counter_ud_ctrl with a behavioural wrapping up/down counter.
module tb_counter_ud_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_load = '0;
  logic [7:0] cfg_up_len = '0;
  logic [7:0] cfg_dn_len = '0;
  logic [3:0] cnt;
  logic       roll;
  logic       load_en, ud, busy, done;
  logic [3:0] load;
  logic [7:0] roll_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_ud_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_load  (cfg_load),
    .cfg_up_len(cfg_up_len),
    .cfg_dn_len(cfg_dn_len),
    .count_i   (cnt),
    .rollover_i(roll),
    .load_en   (load_en),
    .load      (load),
    .ud        (ud),
    .busy      (busy),
    .done      (done),
    .roll_cnt  (roll_cnt)
  );

  // Counter under control: wrap pulse is high in the cycle whose edge wraps.
  assign roll = !load_en && ((ud && cnt == 4'hF) || (!ud && cnt == 4'h0));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load_en) cnt <= load;
    else if (ud) cnt <= cnt + 4'd1;
    else cnt <= cnt - 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input logic [3:0] ld, input logic [7:0] up, input logic [7:0] dn,
                         output int bc, output int dc, output int u0,
                         output logic [3:0] c_load, output logic [3:0] c_done,
                         output bit load_ok, output bit to);
    bc = 0; dc = 0; u0 = 0; c_load = '0; c_done = '0; load_ok = 1'b0; to = 1'b0;
    cfg_load = ld; cfg_up_len = up; cfg_dn_len = dn; start = 1'b1;
    step();
    start = 1'b0;
    cfg_load = 4'h9; cfg_up_len = 8'd1; cfg_dn_len = 8'd7;
    while (busy && !to) begin
      bc++;
      if (bc == 1) load_ok = load_en && (load == ld) && ud;
      if (bc == 2) c_load = cnt;
      if (done) begin dc++; c_done = cnt; end
      if (!ud) u0++;
      step();
      if (bc > 600) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL rst_load_en: got %b want 1", load_en); end
    checks++; if (ud !== 1'b1) begin errors++; $display("FAIL rst_ud: got %b want 1", ud); end
    checks++; if (load !== cnt) begin errors++; $display("FAIL rst_load: got %0d want %0d", load, cnt); end
    checks++; if (roll_cnt !== 8'd0) begin errors++; $display("FAIL rst_roll: got %0d want 0", roll_cnt); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bc, dc, u0; logic [3:0] cl, cd; bit lok, to;
    run_seq(4'd5, 8'd25, 8'd3, bc, dc, u0, cl, cd, lok, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", to); end
    checks++; if (lok !== 1'b1) begin errors++; $display("FAIL basic_load_phase: got %b want 1", lok); end
    checks++; if (cl !== 4'd5) begin errors++; $display("FAIL basic_after_load: got %0d want 5", cl); end
    checks++; if (cd !== 4'd11) begin errors++; $display("FAIL basic_count_done: got %0d want 11", cd); end
    checks++; if (bc !== 30) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 30", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", dc); end
    checks++; if (u0 !== 3) begin errors++; $display("FAIL basic_down_cycles: got %0d want 3", u0); end
    checks++; if (roll_cnt !== 8'd1) begin errors++; $display("FAIL basic_roll: got %0d want 1", roll_cnt); end
    checks++; if (cnt !== 4'd11) begin errors++; $display("FAIL basic_hold_idle: got %0d want 11", cnt); end
  endtask

  task automatic test_zero_len();
    int bc, dc, u0; logic [3:0] cl, cd; bit lok, to;
    run_seq(4'd3, 8'd0, 8'd0, bc, dc, u0, cl, cd, lok, to);
    checks++; if (bc !== 2) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 2", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", dc); end
    checks++; if (cd !== 4'd3) begin errors++; $display("FAIL zero_count: got %0d want 3", cd); end
    checks++; if (roll_cnt !== 8'd0) begin errors++; $display("FAIL zero_roll: got %0d want 0", roll_cnt); end
  endtask

  task automatic test_down_only();
    int bc, dc, u0; logic [3:0] cl, cd; bit lok, to;
    run_seq(4'd1, 8'd0, 8'd4, bc, dc, u0, cl, cd, lok, to);
    checks++; if (u0 !== 4) begin errors++; $display("FAIL down_ud0_cycles: got %0d want 4", u0); end
    checks++; if (cd !== 4'd13) begin errors++; $display("FAIL down_count: got %0d want 13", cd); end
    checks++; if (roll_cnt !== 8'd1) begin errors++; $display("FAIL down_roll: got %0d want 1", roll_cnt); end
    checks++; if (bc !== 6) begin errors++; $display("FAIL down_busy_cycles: got %0d want 6", bc); end
  endtask

  task automatic test_abort();
    cfg_load = 4'd2; cfg_up_len = 8'd25; cfg_dn_len = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    start = 1'b1;
    step(); start = 1'b0;
    checks++; if ({busy, ud, load_en} !== 3'b110) begin errors++; $display("FAIL abort_start_ignored: got %b want 110", {busy, ud, load_en}); end
    step(); step();
    abort = 1'b1;
    step(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
    checks++; if (roll_cnt !== 8'd0) begin errors++; $display("FAIL abort_roll: got %0d want 0", roll_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({busy, done, cnt} !== {2'b00, 4'd8}) begin
        errors++; $display("FAIL abort_frozen: got busy=%b done=%b cnt=%0d want 0 0 8", busy, done, cnt);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc, u0; logic [3:0] cl, cd; bit lok, to;
    cfg_load = 4'd1; cfg_up_len = 8'd0; cfg_dn_len = 8'd4; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    checks++; if ({ud, roll_cnt} !== {1'b0, 8'd1}) begin errors++; $display("FAIL rmid_pre: got ud=%b roll=%0d want 0 1", ud, roll_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, load_en, ud} !== 4'b0011) begin errors++; $display("FAIL rmid_outputs: got %b want 0011", {busy, done, load_en, ud}); end
    checks++; if (roll_cnt !== 8'd0) begin errors++; $display("FAIL rmid_roll: got %0d want 0", roll_cnt); end
    #1 rst = 1'b0;
    run_seq(4'd3, 8'd2, 8'd1, bc, dc, u0, cl, cd, lok, to);
    checks++; if (bc !== 5) begin errors++; $display("FAIL rmid_rerun_busy: got %0d want 5", bc); end
    checks++; if ({dc, cd} !== {32'd1, 4'd4}) begin errors++; $display("FAIL rmid_rerun: got done=%0d cnt=%0d want 1 4", dc, cd); end
  endtask

  task automatic test_long_up();
    int bc, dc, u0; logic [3:0] cl, cd; bit lok, to;
    run_seq(4'd0, 8'd255, 8'd0, bc, dc, u0, cl, cd, lok, to);
    checks++; if (bc !== 257) begin errors++; $display("FAIL long_busy_cycles: got %0d want 257", bc); end
    checks++; if (cd !== 4'd15) begin errors++; $display("FAIL long_count: got %0d want 15", cd); end
    checks++; if (roll_cnt !== 8'd15) begin errors++; $display("FAIL long_roll: got %0d want 15", roll_cnt); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL long_done_pulses: got %0d want 1", dc); end
  endtask

  task automatic test_start_abort_idle();
    cfg_load = 4'd7; cfg_up_len = 8'd2; cfg_dn_len = 8'd2;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sa_idle_busy: got %b want 0", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sa_idle_later: got %b want 0", busy); end
    checks++; if (roll_cnt !== 8'd15) begin errors++; $display("FAIL sa_idle_roll: got %0d want 15", roll_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_down_only();
    test_abort();
    test_reset_mid();
    test_long_up();
    test_start_abort_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_ud_ctrl.md
COUNTER_UD_CTRL -- requirements
Module: counter_ud_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the width of the controlled counter's count and load.
REQ-002 SHALL have parameter LEN_W, default 8, giving the width of phase-length and rollover-tally fields.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to run one load/up/down sequence; sampled only in IDLE.
REQ-006 abort  input  1  terminate the running sequence.
REQ-007 cfg_load  input  WIDTH  preload value for the counter.
REQ-008 cfg_up_len  input  LEN_W  number of count-up cycles.
REQ-009 cfg_dn_len  input  LEN_W  number of count-down cycles.
REQ-010 count_i  input  WIDTH  current counter value.
REQ-011 rollover_i  input  1  one-cycle wrap pulse from the counter, either direction.
REQ-012 load_en  output  1  counter load strobe.
REQ-013 load  output  WIDTH  counter load value.
REQ-014 ud  output  1  counter direction; 1 = up, 0 = down.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 roll_cnt  output  LEN_W  rollovers seen during the current or last sequence.

Function
REQ-018 SHALL implement the states IDLE, LOAD, UP, DOWN and DONE.
REQ-019 In IDLE, start=1 SHALL latch cfg_load, cfg_up_len and cfg_dn_len, clear roll_cnt, and enter LOAD on the next edge; config changes after latching SHALL have no effect.
REQ-020 LOAD SHALL last exactly 1 cycle with load_en=1, load=latched cfg_load and ud=1.
REQ-021 From LOAD the block SHALL go to UP if up_len>0, else to DOWN if dn_len>0, else to DONE.
REQ-022 UP SHALL last exactly up_len cycles with load_en=0 and ud=1, then go to DOWN if dn_len>0, else to DONE.
REQ-023 DOWN SHALL last exactly dn_len cycles with load_en=0 and ud=0, then go to DONE.
REQ-024 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-025 In IDLE and DONE, load_en SHALL be 1 with load=count_i, so the counter holds its value; ud SHALL be 1.
REQ-026 Phase length SHALL be tracked by a down-counter loaded on phase entry; a length of 2^LEN_W-1 SHALL be supported.
REQ-027 roll_cnt SHALL increment on each rollover_i=1 cycle while in UP or DOWN, saturate at 2^LEN_W-1, and otherwise hold.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse; roll_cnt SHALL hold.
REQ-029 abort SHALL take priority over all other transitions.
REQ-030 start while busy SHALL be ignored, with no queuing.
REQ-031 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-032 All outputs except load SHALL be decoded from registered state only; load in IDLE/DONE SHALL be a combinational path from count_i.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, roll_cnt=0, the phase counter to 0 and the latched config to 0.
REQ-034 While rst=1, outputs SHALL be busy=0, done=0, load_en=1, load=count_i, ud=1.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
REQ-036 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-037 Package cud_ctrl_pkg SHALL hold the state enum typedef and the default WIDTH and LEN_W constants.
REQ-038 The phase-length down-counter SHALL be the sub-module cud_len_cnt (load, decrement, zero flag).
REQ-039 The controller SHALL connect to the existing counter_ud through the cud_if signals load_en, load, ud, count and rollover.

Verification
REQ-040 Load 5, up 25, down 3 -> count 5 after LOAD, 14 after UP, 11 at DONE; roll_cnt=1; done pulses once; busy lasts 30 cycles.
REQ-041 Load 3, up 0, down 0 -> IDLE->LOAD->DONE->IDLE; count=3; done=1 for 1 cycle; roll_cnt=0.
REQ-042 Load 1, up 0, down 4 -> count 13, roll_cnt=1 (wrap 0->15), ud=0 for exactly 4 cycles.
REQ-043 Abort in UP cycle 6 of 25 -> IDLE next cycle, done never asserted, count frozen; start mid-run is ignored.
REQ-044 rst pulsed during DOWN -> busy=0 immediately, roll_cnt=0; a new start after release runs normally.
REQ-045 Load 0, up 255, down 0 -> 255 UP cycles, roll_cnt=15, count=15 at DONE.
